// File: rtl/vga_demo_ctrl.sv
// vga_demo_ctrl: raster timing, command shadow regs and
// vblank-aligned commit for the VGA demo datapath.
//
// Ports:
//   clk         pixel clock
//   reset_n     synchronous active-low reset
//   cmd_in      [31] toggle strobe, [27:24] addr, [15:0] data
//   status_out  [31] ack, [17] pending, [16] in_vblank,
//               [15:0] frame_count
//   h_sync      horizontal sync
//   v_sync      vertical sync
//   active      visible pixel and output enabled
//   pix_x       horizontal count
//   pix_y       vertical count
//   frame_start one-cycle pulse at (0,0)
//   scroll_x    committed X scroll
//   scroll_y    committed Y scroll
//   effect      committed effect select
module vga_demo_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] cmd_in,
   output logic [31:0] status_out,
   output logic        h_sync,
   output logic        v_sync,
   output logic        active,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        frame_start,
   output logic [9:0]  scroll_x,
   output logic [9:0]  scroll_y,
   output logic [2:0]  effect
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam logic SYNC_ON  = 1'(SYNC_POL);
   localparam logic SYNC_OFF = ~SYNC_ON;

   localparam logic [3:0] A_CTRL = 4'd0;
   localparam logic [3:0] A_SX   = 4'd1;
   localparam logic [3:0] A_SY   = 4'd2;
   localparam logic [3:0] A_FX   = 4'd3;

   // raster counters
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;

   // command handshake
   logic       last_tog_q;
   logic       accept;
   logic       wr_hit;
   logic [3:0] cmd_addr;
   logic       pend_q, pend_d;
   logic       commit;

   // shadow registers
   logic       sh_en_q, sh_en_d;
   logic       sh_blank_q, sh_blank_d;
   logic [9:0] sh_sx_q, sh_sx_d;
   logic [9:0] sh_sy_q, sh_sy_d;
   logic [2:0] sh_fx_q, sh_fx_d;

   // committed registers
   logic       cm_en_q, cm_en_d;
   logic       cm_blank_q, cm_blank_d;
   logic [9:0] cm_sx_q, cm_sx_d;
   logic [9:0] cm_sy_q, cm_sy_d;
   logic [2:0] cm_fx_q, cm_fx_d;

   // registered raster outputs
   logic [9:0]  pix_x_q;
   logic [9:0]  pix_y_q;
   logic        hs_q;
   logic        vs_q;
   logic        act_q;
   logic        fs_q;
   logic        vblank_q;
   logic [15:0] frame_cnt_q;

   logic at_origin;
   logic unused_cmd;

   assign unused_cmd = ^{cmd_in[30:28], cmd_in[23:10]};

   always_comb begin
      h_d = h_q + 10'd1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         if (v_q == V_LAST) begin
            v_d = '0;
         end else begin
            v_d = v_q + 10'd1;
         end
      end
   end

   assign at_origin = (h_q == '0) && (v_q == '0);
   assign cmd_addr  = cmd_in[27:24];
   assign accept    = cmd_in[31] ^ last_tog_q;
   assign wr_hit    = accept && (cmd_addr <= A_FX);
   assign commit    = (h_q == '0) && (v_q == V_VIS) && pend_q;

   // Shadow writes; addresses above A_FX are acked only.
   always_comb begin
      sh_en_d    = sh_en_q;
      sh_blank_d = sh_blank_q;
      sh_sx_d    = sh_sx_q;
      sh_sy_d    = sh_sy_q;
      sh_fx_d    = sh_fx_q;
      if (accept) begin
         unique case (cmd_addr)
            A_CTRL: begin
               sh_en_d    = cmd_in[0];
               sh_blank_d = cmd_in[1];
            end
            A_SX:    sh_sx_d = cmd_in[9:0];
            A_SY:    sh_sy_d = cmd_in[9:0];
            A_FX:    sh_fx_d = cmd_in[2:0];
            default: ;
         endcase
      end
   end

   // Commit copies the pre-write shadow values; a write in the
   // same cycle stays pending for the following frame.
   always_comb begin
      cm_en_d    = cm_en_q;
      cm_blank_d = cm_blank_q;
      cm_sx_d    = cm_sx_q;
      cm_sy_d    = cm_sy_q;
      cm_fx_d    = cm_fx_q;
      if (commit) begin
         cm_en_d    = sh_en_q;
         cm_blank_d = sh_blank_q;
         cm_sx_d    = sh_sx_q;
         cm_sy_d    = sh_sy_q;
         cm_fx_d    = sh_fx_q;
      end
   end

   always_comb begin
      pend_d = pend_q;
      if (commit) begin
         pend_d = 1'b0;
      end
      if (wr_hit) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         h_q        <= '0;
         v_q        <= '0;
         last_tog_q <= 1'b0;
         pend_q     <= 1'b0;
         sh_en_q    <= 1'b1;
         sh_blank_q <= 1'b0;
         sh_sx_q    <= '0;
         sh_sy_q    <= '0;
         sh_fx_q    <= '0;
         cm_en_q    <= 1'b1;
         cm_blank_q <= 1'b0;
         cm_sx_q    <= '0;
         cm_sy_q    <= '0;
         cm_fx_q    <= '0;
      end else begin
         h_q        <= h_d;
         v_q        <= v_d;
         last_tog_q <= cmd_in[31];
         pend_q     <= pend_d;
         sh_en_q    <= sh_en_d;
         sh_blank_q <= sh_blank_d;
         sh_sx_q    <= sh_sx_d;
         sh_sy_q    <= sh_sy_d;
         sh_fx_q    <= sh_fx_d;
         cm_en_q    <= cm_en_d;
         cm_blank_q <= cm_blank_d;
         cm_sx_q    <= cm_sx_d;
         cm_sy_q    <= cm_sy_d;
         cm_fx_q    <= cm_fx_d;
      end
   end

   // Every raster output is a registered function of (h_q, v_q),
   // so the whole set lags the counters by one cycle in lockstep.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         hs_q        <= SYNC_OFF;
         vs_q        <= SYNC_OFF;
         act_q       <= 1'b0;
         fs_q        <= 1'b0;
         vblank_q    <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         pix_x_q  <= h_q;
         pix_y_q  <= v_q;
         hs_q     <= ((h_q >= HS_BEG) && (h_q <= HS_END)) ?
                     SYNC_ON : SYNC_OFF;
         vs_q     <= ((v_q >= VS_BEG) && (v_q <= VS_END)) ?
                     SYNC_ON : SYNC_OFF;
         act_q    <= (h_q < H_VIS) && (v_q < V_VIS) &&
                     cm_en_d && !cm_blank_d;
         fs_q     <= at_origin;
         vblank_q <= (v_q >= V_VIS);
         if (at_origin) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign h_sync      = hs_q;
   assign v_sync      = vs_q;
   assign active      = act_q;
   assign frame_start = fs_q;
   assign scroll_x    = cm_sx_q;
   assign scroll_y    = cm_sy_q;
   assign effect      = cm_fx_q;
   assign status_out  = {last_tog_q, 13'b0, pend_q, vblank_q,
                         frame_cnt_q};

endmodule

// File: tb/tb_vga_demo_ctrl.sv
// tb_vga_demo_ctrl: directed bench for vga_demo_ctrl using a
// reduced raster (24x18) so whole frames stay short.
module tb_vga_demo_ctrl;

   localparam int HA = 16;
   localparam int HF = 2;
   localparam int HS = 4;
   localparam int HB = 2;
   localparam int VA = 12;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] cmd_in;
   logic [31:0] status_out;
   logic        h_sync;
   logic        v_sync;
   logic        active;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        frame_start;
   logic [9:0]  scroll_x;
   logic [9:0]  scroll_y;
   logic [2:0]  effect;

   int checks = 0;
   int failures = 0;
   logic exp_tog = 1'b0;

   vga_demo_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .cmd_in(cmd_in),
      .status_out(status_out),
      .h_sync(h_sync),
      .v_sync(v_sync),
      .active(active),
      .pix_x(pix_x),
      .pix_y(pix_y),
      .frame_start(frame_start),
      .scroll_x(scroll_x),
      .scroll_y(scroll_y),
      .effect(effect)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advances at least one cycle, then until (x,y) is shown.
   task automatic wait_pos(input int x, input int y);
      int n;
      n = 0;
      tick();
      while (!(pix_x == 10'(x) && pix_y == 10'(y)) && n < 2000) begin
         tick();
         n++;
      end
      check("wait_pos", 32'(n < 2000), 32'd1);
   endtask

   task automatic send(input logic [3:0] a, input logic [15:0] d);
      exp_tog = ~exp_tog;
      cmd_in = {exp_tog, 3'b0, a, 8'b0, d};
   endtask

   task automatic run_frame(output int hs_lo, output int vs_lo,
                            output int act_n, output int fs_n,
                            output int hs_min, output int hs_max);
      hs_lo = 0; vs_lo = 0; act_n = 0; fs_n = 0;
      hs_min = 1023; hs_max = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (!h_sync) begin
            hs_lo++;
            if (int'(pix_x) < hs_min) hs_min = int'(pix_x);
            if (int'(pix_x) > hs_max) hs_max = int'(pix_x);
         end
         if (!v_sync) vs_lo++;
         if (active) act_n++;
         if (frame_start) fs_n++;
         tick();
      end
   endtask

   initial begin
      int hl, vl, an, fn, hmn, hmx;
      reset_n = 1'b0;
      cmd_in = '0;
      tick(); tick(); tick();
      check("rst_pix_x", 32'(pix_x), 32'd0);
      check("rst_pix_y", 32'(pix_y), 32'd0);
      check("rst_fs", 32'(frame_start), 32'd0);
      check("rst_hs", 32'(h_sync), 32'd1);
      check("rst_vs", 32'(v_sync), 32'd1);
      check("rst_status", status_out, 32'd0);
      check("rst_active", 32'(active), 32'd0);

      reset_n = 1'b1;
      tick();
      check("post_pix", {pix_y, pix_x}, 20'd0);
      check("post_active", 32'(active), 32'd1);
      check("post_fs", 32'(frame_start), 32'd1);
      check("post_fcnt", 32'(status_out[15:0]), 32'd1);

      run_frame(hl, vl, an, fn, hmn, hmx);
      check("hs_low_cnt", 32'(hl), 32'(HS * VT));
      check("hs_first_x", 32'(hmn), 32'(HA + HF));
      check("hs_last_x", 32'(hmx), 32'(HA + HF + HS - 1));
      check("vs_low_cnt", 32'(vl), 32'(VS * HT));
      check("active_cnt", 32'(an), 32'(HA * VA));
      check("fs_cnt", 32'(fn), 32'd1);
      check("fcnt_2", 32'(status_out[15:0]), 32'd2);

      // scroll_x write mid-frame, visible only at commit
      wait_pos(0, 5);
      send(4'd1, 16'h0123);
      tick();
      check("ack_1", 32'(status_out[31]), 32'd1);
      check("pend_1", 32'(status_out[17]), 32'd1);
      wait_pos(HT - 1, VA - 1);
      check("sx_before", 32'(scroll_x), 32'd0);
      tick();
      check("sx_commit", 32'(scroll_x), 32'h123);
      check("pend_clr", 32'(status_out[17]), 32'd0);
      check("vblank", 32'(status_out[16]), 32'd1);

      // write landing exactly on the commit cycle
      wait_pos(0, 3);
      send(4'd1, 16'h00AA);
      tick();
      wait_pos(HT - 1, VA - 1);
      send(4'd2, 16'h0005);
      tick();
      check("cc_sx", 32'(scroll_x), 32'h0AA);
      check("cc_sy_hold", 32'(scroll_y), 32'd0);
      check("cc_pend", 32'(status_out[17]), 32'd1);
      wait_pos(0, VA);
      check("cc_sy_next", 32'(scroll_y), 32'd5);
      check("cc_pend_clr", 32'(status_out[17]), 32'd0);

      // blank: whole frame dark, syncs unchanged
      wait_pos(0, 2);
      send(4'd0, 16'h0002);
      tick();
      wait_pos(0, 0);
      run_frame(hl, vl, an, fn, hmn, hmx);
      check("blank_active", 32'(an), 32'd0);
      check("blank_hs", 32'(hl), 32'(HS * VT));
      check("blank_vs", 32'(vl), 32'(VS * HT));

      // ignored address: ack only
      wait_pos(0, 3);
      send(4'd7, 16'hFFFF);
      tick();
      check("a7_ack", 32'(status_out[31]), 32'(exp_tog));
      check("a7_pend", 32'(status_out[17]), 32'd0);
      wait_pos(0, VA);
      check("a7_outs", {scroll_x, scroll_y, effect},
            {10'h0AA, 10'd5, 3'd0});

      // effect plus re-enable
      wait_pos(0, VA + 1);
      send(4'd3, 16'h0005);
      tick();
      send(4'd0, 16'h0001);
      tick();
      wait_pos(0, VA);
      check("effect", 32'(effect), 32'd5);
      wait_pos(0, 0);
      check("reenable", 32'(active), 32'd1);

      // reset mid-frame drops a pending write
      wait_pos(0, 5);
      send(4'd1, 16'h03FF);
      tick();
      check("pre_rst_pend", 32'(status_out[17]), 32'd1);
      wait_pos(0, 6);
      reset_n = 1'b0;
      cmd_in = '0;
      exp_tog = 1'b0;
      tick();
      check("mr_pix", {pix_y, pix_x}, 20'd0);
      check("mr_outs", {scroll_x, scroll_y, effect}, 23'd0);
      check("mr_status", status_out, 32'd0);
      check("mr_sync", {h_sync, v_sync, active, frame_start},
            4'b1100);
      tick();
      reset_n = 1'b1;
      tick();
      check("mr_post", {frame_start, status_out[15:0]},
            {1'b1, 16'd1});
      wait_pos(0, VA);
      check("mr_lost", 32'(scroll_x), 32'd0);
      check("mr_pend", 32'(status_out[17]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
